parking_sensor_gen: RTL and testbench
=====================================

// Module: parking_sensor_gen
// PURPOSE
//  Transmit-side counterpart of the parking-lot detector: converts enter/exit commands into the
//  two-sensor (a,b) quadrature sequence a car produces when crossing the gate. Optionally injects
//  contact bounce on every sensor edge to exercise the debouncers.
//  Sits in the lot bench/demo path, driving sw1/sw2 ahead of debounce -> detector -> BCD counter.
// PARAMETERS
//  HOLD_CYCLES    16   stable cycles per sensor phase; must be >= 1
//  BOUNCE_CYCLES  6    bounce cycles before each stable phase when bounce enabled; 0 disables bounce
//  CNT_W          8    width of completed enter/exit event counters
// PORTS
//  clk            in   1      system clock
//  async_reset_n  in   1      asynchronous active-low reset
//  cmd_valid      in   1      command request
//  cmd_dir        in   1      0 = car enters, 1 = car exits; sampled on accept
//  cmd_ready      out  1      high only in IDLE; accept = cmd_valid & cmd_ready
//  bounce_en      in   1      sampled on accept; enables bounce for the whole command
//  a              out  1      outer sensor level
//  b              out  1      inner sensor level
//  busy           out  1      high from the cycle after accept through the last PH4 cycle
//  done           out  1      one-cycle pulse when a command completes
//  enter_cnt      out  CNT_W  completed enter commands, wraps modulo 2^CNT_W
//  exit_cnt       out  CNT_W  completed exit commands, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (asynchronous, any state): a=b=0, cmd_ready=1, busy=0, done=0, counters=0, FSM=IDLE.
//   Reset mid-sequence abandons the command; the counter is not incremented.
//  FSM: IDLE -> PH1 -> PH2 -> PH3 -> PH4 -> IDLE. All outputs are registered.
//   {a,b} per phase:  enter: PH1=10, PH2=11, PH3=01, PH4=00.
//                     exit:  PH1=01, PH2=11, PH3=10, PH4=00.
//   IDLE drives {a,b}=00. cmd_valid outside IDLE is ignored; no queuing.
//  Phase length P = HOLD_CYCLES + (bounce_en_latched ? BOUNCE_CYCLES : 0).
//   The phase timer is sized for the maximum P.
//  Bounce: exactly one sensor changes per phase transition.
//   During bounce cycle k (0-based), the changing sensor = new level if k even, old level if k odd.
//   Then the new level is held for HOLD_CYCLES. The unchanged sensor is steady throughout.
//  Timing (accept at cycle t):
//   PH1 occupies t+1 .. t+P; PHn occupies t+1+(n-1)P .. t+nP.
//   At t+4P+1: FSM=IDLE, done=1, cmd_ready=1, matching counter increments.
//   A new command may be accepted at t+4P+1, the same cycle as done.
//   Back-to-back commands give one IDLE cycle of {a,b}=00 between sequences.
//  busy = ~cmd_ready. done never coincides with busy.
//  Counter wrap: at 2^CNT_W-1, the next completion gives 0. No saturation, no overflow flag.
// TESTING
//  1 Reset: hold async_reset_n=0 mid-PH2 -> a=b=0, cmd_ready=1, counters=0 immediately
//    (no clock edge needed).
//  2 Enter, HOLD=2, bounce off, accept at cycle 0 -> {a,b}: c1-2=10, c3-4=11, c5-6=01, c7-8=00;
//    done=1 at c9; enter_cnt=1.
//  3 Exit, HOLD=2, BOUNCE=3, bounce_en=1 -> PH1: b=1,0,1 then 1,1 (a=0); done at c21; exit_cnt=1.
//  4 Back-to-back: cmd_valid held high with alternating dir -> next accept on the done cycle;
//    exactly one 00 IDLE cycle; cmd_valid while busy is ignored.
//  5 Wrap: CNT_W=2, five enters -> enter_cnt sequence 1,2,3,0,1; exit_cnt stays 0.
//  6 Loop through debounce+detector (HOLD > debounce window) -> exactly one inc per enter and
//    one dec per exit, with bounce on and off.

Source files
------------

// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen: turns enter/exit commands into the a/b gate-sensor quadrature sequence,
// with optional contact bounce on each sensor edge.
module parking_sensor_gen #(
    parameter int HOLD_CYCLES   = 16,
    parameter int BOUNCE_CYCLES = 6,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    output logic             cmd_ready,
    input  logic             bounce_en,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] enter_cnt,
    output logic [CNT_W-1:0] exit_cnt
);
    localparam int MAX_P = HOLD_CYCLES + BOUNCE_CYCLES;
    localparam int TW    = MAX_P > 1 ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             dir_q, dir_d, bnc_q, bnc_d, done_q, done_d, last;
    logic [1:0]       ab_q, ab_d;
    logic [CNT_W-1:0] enter_q, enter_d, exit_q, exit_d;

    // Enter pattern; an exit is the same walk with the two sensors swapped.
    function automatic logic [1:0] pat(input state_t s, input logic dir);
        logic [1:0] e;
        e = s == PH1 ? 2'b10 : s == PH2 ? 2'b11 : s == PH3 ? 2'b01 : 2'b00;
        return dir ? {e[0], e[1]} : e;
    endfunction

    always_comb begin
        last    = timer_q == (bnc_q ? TW'(MAX_P - 1) : TW'(HOLD_CYCLES - 1));
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        dir_d   = dir_q;
        bnc_d   = bnc_q;
        done_d  = 1'b0;
        enter_d = enter_q;
        exit_d  = exit_q;
        if (state_q == IDLE) begin
            timer_d = '0;
            if (cmd_valid) begin
                state_d = PH1;
                dir_d   = cmd_dir;
                bnc_d   = bounce_en;
            end
        end else if (last) begin
            timer_d = '0;
            state_d = state_q == PH4 ? IDLE : state_t'(state_q + 3'd1);
            if (state_q == PH4) begin
                done_d  = 1'b1;
                enter_d = dir_q ? enter_q : enter_q + 1'b1;
                exit_d  = dir_q ? exit_q + 1'b1 : exit_q;
            end
        end
        // Odd bounce cycles fall back to the previous phase's level on the changing sensor.
        ab_d = (bnc_d && timer_d < TW'(BOUNCE_CYCLES) && timer_d[0])
             ? pat(state_t'(state_d - 3'd1), dir_d) : pat(state_d, dir_d);
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
            bnc_q   <= 1'b0;
            ab_q    <= 2'b00;
            done_q  <= 1'b0;
            enter_q <= '0;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            bnc_q   <= bnc_d;
            ab_q    <= ab_d;
            done_q  <= done_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = ~cmd_ready;
    assign {a, b}    = ab_q;
    assign done      = done_q;
    assign enter_cnt = enter_q;
    assign exit_cnt  = exit_q;
endmodule

// File: tb/tb_parking_sensor_gen.sv
// tb_parking_sensor_gen: random commands checked cycle by cycle against a queue of expected
// sensor waveforms built from the phase tables.
module tb_parking_sensor_gen;
    localparam int HOLD = 2, BOUNCE = 3, CW = 2;

    logic clk = 1'b0, async_reset_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_dir = 1'b0, bounce_en = 1'b0;
    logic cmd_ready, a, b, busy, done;
    logic [CW-1:0] enter_cnt, exit_cnt;

    parking_sensor_gen #(.HOLD_CYCLES(HOLD), .BOUNCE_CYCLES(BOUNCE), .CNT_W(CW)) dut (
        .clk(clk), .async_reset_n(async_reset_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready), .bounce_en(bounce_en), .a(a), .b(b), .busy(busy), .done(done),
        .enter_cnt(enter_cnt), .exit_cnt(exit_cnt));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ab;
        logic       rdy;
        logic       dn;
        logic       en_inc;
        logic       ex_inc;
    } exp_t;

    localparam logic [1:0] ENTER_SEQ [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    localparam logic [1:0] EXIT_SEQ  [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    exp_t          q[$];
    int            checks = 0, errors = 0;
    logic [CW-1:0] en_m = '0, ex_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic dir, input logic be);
        int p;
        exp_t e;
        p = HOLD + (be ? BOUNCE : 0);
        for (int n = 1; n <= 4; n++)
            for (int k = 0; k < p; k++) begin
                e = '0;
                if (be && k < BOUNCE && k % 2 == 1)
                    e.ab = dir ? EXIT_SEQ[n-1] : ENTER_SEQ[n-1];
                else
                    e.ab = dir ? EXIT_SEQ[n] : ENTER_SEQ[n];
                q.push_back(e);
            end
        e = '0;
        e.rdy = 1'b1;
        e.dn = 1'b1;
        e.en_inc = !dir;
        e.ex_inc = dir;
        q.push_back(e);
    endtask

    task automatic cycle(input logic v, input logic d, input logic be);
        exp_t e;
        @(negedge clk);
        e = '0;
        e.rdy = 1'b1;
        if (q.size() > 0) e = q.pop_front();
        en_m = en_m + CW'(e.en_inc);
        ex_m = ex_m + CW'(e.ex_inc);
        check("ab", {30'd0, a, b}, {30'd0, e.ab});
        check("ready", {31'd0, cmd_ready}, {31'd0, e.rdy});
        check("busy", {31'd0, busy}, {31'd0, !e.rdy});
        check("done", {31'd0, done}, {31'd0, e.dn});
        check("enter_cnt", 32'(enter_cnt), 32'(en_m));
        check("exit_cnt", 32'(exit_cnt), 32'(ex_m));
        cmd_valid = v;
        cmd_dir = d;
        bounce_en = be;
        if (e.rdy && v) push_cmd(d, be);
    endtask

    initial begin
        #12;
        check("rst_ab", {30'd0, a, b}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_cnt", {enter_cnt, exit_cnt}, 32'd0);
        @(negedge clk);
        async_reset_n = 1'b1;
        // Directed: enter without bounce, exit with bounce.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (22) cycle(1'b0, 1'b0, 1'b0);
        // cmd_valid held high: back-to-back accepts on the done cycle, ignored while busy.
        for (int i = 0; i < 150; i++) cycle(1'b1, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 400; i++) cycle($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom));
        // Reset in the middle of PH2 must take effect with no clock edge.
        while (q.size() > 0) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        #2 async_reset_n = 1'b0;
        #1;
        check("arst_ab", {30'd0, a, b}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_cnt", {enter_cnt, exit_cnt}, 32'd0);
        q.delete();
        en_m = '0;
        ex_m = '0;
        repeat (2) @(negedge clk);
        async_reset_n = 1'b1;
        for (int i = 0; i < 200; i++) cycle($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
